// File: rtl/uart_sample_loader.sv
// Pairs received UART bytes little-endian into samples, buffers one frame of N samples,
// then streams the frame over valid/ready. Optional feature macro: BYTE_TIMEOUT_EN.
module uart_sample_loader #(
  parameter int          bit_width = 8,
  parameter int          N         = 32,
  parameter int          SIZE      = 5,
  parameter logic [15:0] TIMEOUT   = 16'd52070
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [bit_width-1:0]   rx_data_i,
  input  logic                   rx_done_i,
  output logic [2*bit_width-1:0] sample_o,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic [SIZE-1:0]        sample_idx_o,
  output logic                   frame_last_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {S_FILL, S_LOAD, S_SEND} state_t;

  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);

  state_t                 state, state_nxt;
  logic                   byte_sel;
  logic [bit_width-1:0]   low_byte;
  logic [SIZE-1:0]        wr_ptr;
  logic [SIZE-1:0]        rd_ptr;
  logic [2*bit_width-1:0] mem [N];

  logic fill_byte;
  logic store_sample;
  logic frame_done;
  logic xfer;
  logic gap_expired;

  assign fill_byte    = (state == S_FILL) && rx_done_i;
  assign store_sample = fill_byte && byte_sel;
  assign frame_done   = store_sample && (wr_ptr == LAST_IDX);
  assign xfer         = (state == S_SEND) && sample_valid_o && sample_ready_i;

  assign busy_o       = (state != S_FILL);
  assign frame_last_o = sample_valid_o && (sample_idx_o == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (frame_done) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SEND;
      S_SEND:  if (xfer) state_nxt = (rd_ptr == LAST_IDX) ? S_FILL : S_LOAD;
      default: state_nxt = S_FILL;
    endcase
  end

  // Byte pairing; wr_ptr wraps to 0 by width after the last sample of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_sel <= 1'b0;
      low_byte <= '0;
      wr_ptr   <= '0;
    end else if (fill_byte) begin
      if (!byte_sel) begin
        low_byte <= rx_data_i;
        byte_sel <= 1'b1;
      end else begin
        byte_sel <= 1'b0;
        wr_ptr   <= wr_ptr + 1'b1;
      end
    end else if (gap_expired) begin
      byte_sel <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (store_sample) mem[wr_ptr] <= {rx_data_i, low_byte};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (frame_done) begin
      rd_ptr <= '0;
    end else if (xfer && (rd_ptr != LAST_IDX)) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Output register stays frozen in S_SEND until the consumer takes the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_o       <= '0;
      sample_idx_o   <= '0;
      sample_valid_o <= 1'b0;
    end else if (state == S_LOAD) begin
      sample_o       <= mem[rd_ptr];
      sample_idx_o   <= rd_ptr;
      sample_valid_o <= 1'b1;
    end else if (xfer) begin
      sample_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_o <= 1'b0;
    else        overrun_o <= rx_done_i && (state != S_FILL);
  end

`ifdef BYTE_TIMEOUT_EN
  logic [15:0] gap_cnt;

  assign gap_expired = (state == S_FILL) && byte_sel && !rx_done_i && (gap_cnt == TIMEOUT);

  // Counts idle cycles while a low byte waits for its partner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= gap_expired;
      if ((state != S_FILL) || !byte_sel || rx_done_i || gap_expired) gap_cnt <= '0;
      else                                                            gap_cnt <= gap_cnt + 16'd1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign gap_expired    = 1'b0;
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_sample_loader.sv
// Directed bench for uart_sample_loader: frames, backpressure, overrun, timeout, resets.
module tb_uart_sample_loader;

  localparam int          BW      = 8;
  localparam int          N       = 32;
  localparam int          SIZE    = 5;
  localparam logic [15:0] TIMEOUT = 16'd52070;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [BW-1:0]   rx_data = '0;
  logic            rx_done = 1'b0;
  logic [2*BW-1:0] sample;
  logic            sample_valid;
  logic            sample_ready = 1'b1;
  logic [SIZE-1:0] sample_idx;
  logic            frame_last;
  logic            busy;
  logic            overrun;
  logic            timeout;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int to_cnt = 0;

  logic [7:0]      stream     [64];
  logic [15:0]     got_sample [N];
  logic [SIZE-1:0] got_idx    [N];
  logic            got_last   [N];
  int n_got, stall_changed, stall_seen, timed_out;

  uart_sample_loader #(.bit_width(BW), .N(N), .SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data), .rx_done_i(rx_done),
    .sample_o(sample), .sample_valid_o(sample_valid), .sample_ready_i(sample_ready),
    .sample_idx_o(sample_idx), .frame_last_o(frame_last), .busy_o(busy),
    .overrun_o(overrun), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (timeout) to_cnt++;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_stream(input int first, input int count);
    for (int k = first; k < first + count; k++) send_byte(stream[k]);
  endtask

  // Drains one frame; optional stall on one index and optional dropped strobes while busy.
  task automatic collect_frame(input int stall_at, input int stall_len, input int ovr_bytes);
    int cyc, stall_left, ovr_left;
    logic strobe_gap;
    logic [15:0] held_s;
    logic [SIZE-1:0] held_i;
    n_got = 0; stall_changed = 0; stall_seen = 0; timed_out = 0;
    cyc = 0; stall_left = stall_len; ovr_left = ovr_bytes; strobe_gap = 1'b0;
    held_s = '0; held_i = '0;
    while (n_got < N) begin
      if (cyc >= 4 * N + 200) begin
        timed_out = 1;
        break;
      end
      if (sample_valid) begin
        if (stall_left > 0 && sample_idx == SIZE'(stall_at)) begin
          if (stall_left == stall_len) begin
            held_s = sample;
            held_i = sample_idx;
          end else if (sample !== held_s || sample_idx !== held_i) begin
            stall_changed++;
          end
          stall_seen++;
          stall_left--;
          sample_ready = 1'b0;
        end else begin
          if (stall_len > 0 && stall_left == 0 && sample_idx == SIZE'(stall_at) && sample !== held_s)
            stall_changed++;
          sample_ready = 1'b1;
          got_sample[n_got] = sample;
          got_idx[n_got]    = sample_idx;
          got_last[n_got]   = frame_last;
          n_got++;
        end
      end else begin
        sample_ready = 1'b1;
      end
      if (ovr_left > 0 && busy && !strobe_gap) begin
        rx_data = 8'hEE;
        rx_done = 1'b1;
        ovr_left--;
        strobe_gap = 1'b1;
      end else begin
        rx_done = 1'b0;
        strobe_gap = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    rx_done = 1'b0;
    sample_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (sample !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sample got %h want 0000", sample); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", sample_valid); end
    checks++; if (sample_idx !== 5'd0) begin errors++; $display("[TB] FAIL reset_idx got %0d want 0", sample_idx); end
    checks++; if (frame_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %b want 0", frame_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b want 0", timeout); end
  endtask

  task automatic test_normal_frame();
    for (int k = 0; k < 64; k++) stream[k] = 8'(k);
    send_stream(0, 63);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL normal_busy_before_last got %b want 0", busy); end
    rx_data = stream[63];
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL normal_busy_after_last got %b want 1", busy); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL normal_valid_cycle1 got %b want 0", sample_valid); end
    @(negedge clk);
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("[TB] FAIL normal_valid_cycle2 got %b want 1", sample_valid); end
    checks++; if (sample !== 16'h0100) begin errors++; $display("[TB] FAIL normal_first_sample got %h want 0100", sample); end
    collect_frame(-1, 0, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("[TB] FAIL normal_timeout got %0d samples want %0d", n_got, N); end
    for (int i = 0; i < n_got; i++) begin
      checks++;
      if (got_sample[i] !== {8'(2 * i + 1), 8'(2 * i)} || got_idx[i] !== SIZE'(i) || got_last[i] !== (i == N - 1)) begin
        errors++;
        $display("[TB] FAIL normal_sample%0d got %h/%0d/%b want %h/%0d/%b", i, got_sample[i], got_idx[i],
                 got_last[i], {8'(2 * i + 1), 8'(2 * i)}, i, (i == N - 1));
      end
    end
    checks++; if (got_sample[N-1] !== 16'h3F3E) begin errors++; $display("[TB] FAIL normal_last_sample got %h want 3F3E", got_sample[N-1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL normal_busy_end got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 64; k++) stream[k] = 8'(3 * k + 7);
    send_stream(0, 64);
    collect_frame(5, 10, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("[TB] FAIL bp_timeout got %0d samples want %0d", n_got, N); end
    checks++; if (stall_seen !== 10) begin errors++; $display("[TB] FAIL bp_stall_cycles got %0d want 10", stall_seen); end
    checks++; if (stall_changed !== 0) begin errors++; $display("[TB] FAIL bp_stable got %0d changes want 0", stall_changed); end
    for (int i = 0; i < n_got; i++) begin
      checks++;
      if (got_sample[i] !== {stream[2*i+1], stream[2*i]} || got_idx[i] !== SIZE'(i)) begin
        errors++;
        $display("[TB] FAIL bp_sample%0d got %h/%0d want %h/%0d", i, got_sample[i], got_idx[i], {stream[2*i+1], stream[2*i]}, i);
      end
    end
  endtask

  task automatic test_overrun();
    int ovr0;
    for (int k = 0; k < 64; k++) stream[k] = 8'(k) ^ 8'h5A;
    send_stream(0, 64);
    ovr0 = ovr_cnt;
    collect_frame(-1, 0, 3);
    @(negedge clk);
    checks++; if (ovr_cnt - ovr0 !== 3) begin errors++; $display("[TB] FAIL ovr_pulses got %0d want 3", ovr_cnt - ovr0); end
    for (int i = 0; i < n_got; i++) begin
      checks++;
      if (got_sample[i] !== {stream[2*i+1], stream[2*i]}) begin
        errors++;
        $display("[TB] FAIL ovr_sample%0d got %h want %h", i, got_sample[i], {stream[2*i+1], stream[2*i]});
      end
    end
    for (int k = 0; k < 64; k++) stream[k] = 8'h80 + 8'(k);
    send_stream(0, 64);
    collect_frame(-1, 0, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("[TB] FAIL ovr_next_timeout got %0d samples want %0d", n_got, N); end
    checks++; if (got_sample[0] !== 16'h8180) begin errors++; $display("[TB] FAIL ovr_next_first got %h want 8180", got_sample[0]); end
    for (int i = 1; i < n_got; i++) begin
      checks++;
      if (got_sample[i] !== {stream[2*i+1], stream[2*i]}) begin
        errors++;
        $display("[TB] FAIL ovr_next_sample%0d got %h want %h", i, got_sample[i], {stream[2*i+1], stream[2*i]});
      end
    end
  endtask

  task automatic test_timeout();
    int to0;
    to0 = to_cnt;
    for (int k = 0; k < 64; k++) stream[k] = 8'(k);
`ifdef BYTE_TIMEOUT_EN
    stream[0] = 8'h11;
    stream[1] = 8'h22;
    send_byte(8'hAA);
    repeat (int'(TIMEOUT) + 5) @(negedge clk);
    send_stream(0, 64);
`else
    stream[0] = 8'hAA;
    stream[1] = 8'h11;
    stream[2] = 8'h22;
    send_byte(stream[0]);
    repeat (int'(TIMEOUT) + 5) @(negedge clk);
    send_stream(1, 63);
`endif
    collect_frame(-1, 0, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("[TB] FAIL to_frame_timeout got %0d samples want %0d", n_got, N); end
`ifdef BYTE_TIMEOUT_EN
    checks++; if (to_cnt - to0 !== 1) begin errors++; $display("[TB] FAIL to_pulses got %0d want 1", to_cnt - to0); end
    checks++; if (got_sample[0] !== 16'h2211) begin errors++; $display("[TB] FAIL to_first got %h want 2211", got_sample[0]); end
`else
    checks++; if (to_cnt - to0 !== 0) begin errors++; $display("[TB] FAIL to_pulses got %0d want 0", to_cnt - to0); end
    checks++; if (got_sample[0] !== 16'h11AA) begin errors++; $display("[TB] FAIL to_first got %h want 11AA", got_sample[0]); end
`endif
    for (int i = 1; i < n_got; i++) begin
      checks++;
      if (got_sample[i] !== {stream[2*i+1], stream[2*i]}) begin
        errors++;
        $display("[TB] FAIL to_sample%0d got %h want %h", i, got_sample[i], {stream[2*i+1], stream[2*i]});
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    for (int k = 0; k < 64; k++) stream[k] = 8'(k);
    send_stream(0, 21);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || sample_valid !== 1'b0 || sample !== 16'h0000 || sample_idx !== 5'd0
                  || frame_last !== 1'b0 || overrun !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstfill_outputs got busy=%b valid=%b sample=%h idx=%0d want all 0", busy, sample_valid, sample, sample_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 64; k++) stream[k] = 8'hC0 ^ 8'(k);
    send_stream(0, 64);
    collect_frame(-1, 0, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("[TB] FAIL rstfill_timeout got %0d samples want %0d", n_got, N); end
    for (int i = 0; i < n_got; i++) begin
      checks++;
      if (got_sample[i] !== {stream[2*i+1], stream[2*i]} || got_idx[i] !== SIZE'(i)) begin
        errors++;
        $display("[TB] FAIL rstfill_sample%0d got %h/%0d want %h/%0d", i, got_sample[i], got_idx[i], {stream[2*i+1], stream[2*i]}, i);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    for (int k = 0; k < 64; k++) stream[k] = 8'(k) + 8'h10;
    send_stream(0, 64);
    sample_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sample_valid !== 1'b1 || sample !== 16'h1110) begin errors++; $display("[TB] FAIL rstsend_pre got valid=%b sample=%h want 1/1110", sample_valid, sample); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sample_valid !== 1'b0 || busy !== 1'b0 || sample !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL rstsend_async got valid=%b busy=%b sample=%h want 0/0/0000", sample_valid, busy, sample);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sample_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ovr0;
    ovr0 = ovr_cnt;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 64; k++) stream[k] = (f == 0) ? 8'(k) + 8'h40 : ~8'(k);
      send_stream(0, 64);
      collect_frame(-1, 0, 0);
      checks++; if (timed_out !== 0) begin errors++; $display("[TB] FAIL b2b_f%0d_timeout got %0d samples want %0d", f, n_got, N); end
      for (int i = 0; i < n_got; i++) begin
        checks++;
        if (got_sample[i] !== {stream[2*i+1], stream[2*i]} || got_idx[i] !== SIZE'(i)) begin
          errors++;
          $display("[TB] FAIL b2b_f%0d_sample%0d got %h/%0d want %h/%0d", f, i, got_sample[i], got_idx[i], {stream[2*i+1], stream[2*i]}, i);
        end
      end
    end
    @(negedge clk);
    checks++; if (ovr_cnt - ovr0 !== 0) begin errors++; $display("[TB] FAIL b2b_overrun got %0d want 0", ovr_cnt - ovr0); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_normal_frame();
    test_backpressure();
    test_overrun();
    test_timeout();
    test_reset_mid_fill();
    test_reset_mid_send();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
